// File: rtl/gpio_irq_ctrl.sv
// Memory-mapped GPIO controller with atomic SET/CLR, a 2-flop synchroniser, a per-pin
// debounce filter and per-pin edge interrupts latched in a W1C status register.
module gpio_irq_ctrl #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int GPIO_WIDTH = 8,
  parameter int DEB_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  i_sel,
  input  logic                  i_we,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  output logic [DATA_WIDTH-1:0] o_rdata,
  output logic                  o_irq,
  inout  wire  [GPIO_WIDTH-1:0] gpio_pins
);

  localparam int CNT_W = (DEB_CYCLES > 0) ? $clog2(DEB_CYCLES + 1) : 1;

  localparam logic [ADDR_WIDTH-1:0] A_DATA = ADDR_WIDTH'(8'h00);
  localparam logic [ADDR_WIDTH-1:0] A_DIR  = ADDR_WIDTH'(8'h04);
  localparam logic [ADDR_WIDTH-1:0] A_READ = ADDR_WIDTH'(8'h08);
  localparam logic [ADDR_WIDTH-1:0] A_SET  = ADDR_WIDTH'(8'h0C);
  localparam logic [ADDR_WIDTH-1:0] A_CLR  = ADDR_WIDTH'(8'h10);
  localparam logic [ADDR_WIDTH-1:0] A_RISE = ADDR_WIDTH'(8'h14);
  localparam logic [ADDR_WIDTH-1:0] A_FALL = ADDR_WIDTH'(8'h18);
  localparam logic [ADDR_WIDTH-1:0] A_STAT = ADDR_WIDTH'(8'h1C);

  logic [GPIO_WIDTH-1:0] data_reg, dir_reg, rise_en_reg, fall_en_reg, irq_stat_reg;
  logic [GPIO_WIDTH-1:0] sync1_reg, sync2_reg, filt_q_reg;
  logic [GPIO_WIDTH-1:0] filt, rise, fall, w1c, irq_stat_next, wbits, rd_pins;
  logic                  wr;
  logic                  unused_wdata;

  assign wr           = i_sel && i_we;
  assign wbits        = i_wdata[GPIO_WIDTH-1:0];
  assign unused_wdata = ^i_wdata;

  // Pads: drive only where DIR selects output, otherwise release the line.
  for (genvar gi = 0; gi < GPIO_WIDTH; gi++) begin : g_pad
    assign gpio_pins[gi] = dir_reg[gi] ? data_reg[gi] : 1'bz;
  end

  if (DEB_CYCLES == 0) begin : g_bypass
    assign filt = sync2_reg;
  end else begin : g_deb
    for (genvar gi = 0; gi < GPIO_WIDTH; gi++) begin : g_pin
      logic [CNT_W-1:0] cnt_reg;
      logic             filt_reg;
      // cnt_reg counts consecutive cycles where the synchronised level differs from filt.
      always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
          cnt_reg  <= '0;
          filt_reg <= 1'b0;
        end else if (sync2_reg[gi] == filt_reg) begin
          cnt_reg <= '0;
        end else if (cnt_reg == CNT_W'(DEB_CYCLES - 1)) begin
          filt_reg <= sync2_reg[gi];
          cnt_reg  <= '0;
        end else begin
          cnt_reg <= cnt_reg + CNT_W'(1);
        end
      end
      assign filt[gi] = filt_reg;
    end
  end

  assign rise          = filt & ~filt_q_reg;
  assign fall          = ~filt & filt_q_reg;
  assign w1c           = (wr && i_addr == A_STAT) ? wbits : '0;
  // New events are OR-ed in after the clear, so an event beats a same-cycle W1C.
  assign irq_stat_next = (irq_stat_reg & ~w1c) | (rise & rise_en_reg) | (fall & fall_en_reg);
  assign o_irq         = |irq_stat_reg;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      data_reg     <= '0;
      dir_reg      <= '0;
      rise_en_reg  <= '0;
      fall_en_reg  <= '0;
      irq_stat_reg <= '0;
      sync1_reg    <= '0;
      sync2_reg    <= '0;
      filt_q_reg   <= '0;
    end else begin
      if (wr) begin
        case (i_addr)
          A_DATA:  data_reg    <= wbits;
          A_DIR:   dir_reg     <= wbits;
          A_SET:   data_reg    <= data_reg | wbits;
          A_CLR:   data_reg    <= data_reg & ~wbits;
          A_RISE:  rise_en_reg <= wbits;
          A_FALL:  fall_en_reg <= wbits;
          default: ;
        endcase
      end
      irq_stat_reg <= irq_stat_next;
      sync1_reg    <= gpio_pins;
      sync2_reg    <= sync1_reg;
      filt_q_reg   <= filt;
    end
  end

  always_comb begin
    rd_pins = '0;
    if (i_sel && !i_we) begin
      case (i_addr)
        A_DATA:  rd_pins = data_reg;
        A_DIR:   rd_pins = dir_reg;
        A_READ:  rd_pins = filt;
        A_RISE:  rd_pins = rise_en_reg;
        A_FALL:  rd_pins = fall_en_reg;
        A_STAT:  rd_pins = irq_stat_reg;
        default: rd_pins = '0;
      endcase
    end
    o_rdata = '0;
    o_rdata[GPIO_WIDTH-1:0] = rd_pins;
  end

endmodule

// File: tb/tb_gpio_irq_ctrl.sv
// Directed and randomized checks of gpio_irq_ctrl against a behavioural model that
// treats debounce as "last DEB_CYCLES synchronised samples all differ from filt".
module tb_gpio_irq_ctrl;
  localparam int AW = 5, DW = 32, GW = 8, DEB = 4;

  logic          clk = 1'b0, resetn = 1'b0, i_sel = 1'b0, i_we = 1'b0;
  logic [AW-1:0] i_addr = '0;
  logic [DW-1:0] i_wdata = '0;
  logic [DW-1:0] o_rdata;
  logic          o_irq;
  wire  [GW-1:0] gpio_pins;
  logic [GW-1:0] tb_val = '0;
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  gpio_irq_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .GPIO_WIDTH(GW), .DEB_CYCLES(DEB)) dut (
    .clk(clk), .resetn(resetn), .i_sel(i_sel), .i_we(i_we), .i_addr(i_addr),
    .i_wdata(i_wdata), .o_rdata(o_rdata), .o_irq(o_irq), .gpio_pins(gpio_pins)
  );

  // ---------------- reference model ----------------
  logic [GW-1:0] m_data = '0, m_dir = '0, m_rise = '0, m_fall = '0, m_stat = '0;
  logic [GW-1:0] m_filt = '0, m_filt_q = '0;
  logic [GW-1:0] m_hist [DEB+1] = '{default: '0};  // m_hist[k]: pad sampled k+1 edges ago
  logic [GW-1:0] m_pad, m_flip, m_w1c, m_stat_next, m_wd;
  logic          m_wr;

  // The bench drives every pin the DUT is not supposed to drive.
  for (genvar gi = 0; gi < GW; gi++) begin : g_drv
    assign gpio_pins[gi] = m_dir[gi] ? 1'bz : tb_val[gi];
  end

  always_comb begin
    m_pad  = (m_dir & m_data) | (~m_dir & tb_val);
    m_flip = '1;
    for (int k = 1; k <= DEB; k++) m_flip = m_flip & (m_hist[k] ^ m_filt);
    m_wr   = i_sel && i_we;
    m_wd   = i_wdata[GW-1:0];
    m_w1c  = (m_wr && i_addr == 5'h1C) ? m_wd : '0;
    m_stat_next = (m_stat & ~m_w1c) | (m_filt & ~m_filt_q & m_rise) | (~m_filt & m_filt_q & m_fall);
  end

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      m_data <= '0; m_dir <= '0; m_rise <= '0; m_fall <= '0; m_stat <= '0;
      m_filt <= '0; m_filt_q <= '0;
      for (int k = 0; k <= DEB; k++) m_hist[k] <= '0;
    end else begin
      m_stat   <= m_stat_next;
      m_filt_q <= m_filt;
      m_filt   <= m_filt ^ m_flip;
      m_hist[0] <= m_pad;
      for (int k = 1; k <= DEB; k++) m_hist[k] <= m_hist[k-1];
      if (m_wr) begin
        case (i_addr)
          5'h00: m_data <= m_wd;
          5'h04: m_dir  <= m_wd;
          5'h0C: m_data <= m_data | m_wd;
          5'h10: m_data <= m_data & ~m_wd;
          5'h14: m_rise <= m_wd;
          5'h18: m_fall <= m_wd;
          default: ;
        endcase
      end
    end
  end

  function automatic logic [DW-1:0] mread(input logic [AW-1:0] a);
    logic [GW-1:0] v;
    case (a)
      5'h00:   v = m_data;
      5'h04:   v = m_dir;
      5'h08:   v = m_filt;
      5'h14:   v = m_rise;
      5'h18:   v = m_fall;
      5'h1C:   v = m_stat;
      default: v = '0;
    endcase
    return DW'(v);
  endfunction

  // ---------------- helpers ----------------
  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    @(negedge clk);
    i_sel = 1'b1; i_we = 1'b1; i_addr = a; i_wdata = d;
    @(posedge clk); #1;
    i_sel = 1'b0; i_we = 1'b0; i_wdata = '0;
  endtask

  task automatic rd(input logic [AW-1:0] a, input string tag);
    @(negedge clk);
    i_sel = 1'b1; i_we = 1'b0; i_addr = a; #1;
    chk(tag, o_rdata, mread(a));
    i_sel = 1'b0;
  endtask

  task automatic rdk(input logic [AW-1:0] a, input logic [DW-1:0] exp, input string tag);
    @(negedge clk);
    i_sel = 1'b1; i_we = 1'b0; i_addr = a; #1;
    chk(tag, o_rdata, exp);
    i_sel = 1'b0;
  endtask

  task automatic ticks(input int n);
    repeat (n) @(posedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [AW-1:0] ra;
    int            op;

    // 1. reset state
    repeat (3) @(posedge clk);
    @(negedge clk); resetn = 1'b1;
    for (int i = 0; i < 8; i++) rdk(AW'(i * 4), 0, $sformatf("reset_reg%0h", i * 4));
    chk("reset_irq", 32'(o_irq), 0);
    @(negedge clk); tb_val = 8'h5A; #1;
    chk("reset_pads_z", 32'(gpio_pins), 32'h5A);
    @(negedge clk); tb_val = 8'h00;
    ticks(8);

    // 2. output path with SET/CLR
    wr(5'h04, 32'hFF); wr(5'h00, 32'h0F); wr(5'h0C, 32'h30); wr(5'h10, 32'h03);
    rdk(5'h00, 32'h3C, "data_setclr");
    chk("pads_drive", 32'(gpio_pins), 32'h3C);
    ticks(6);
    rdk(5'h08, 32'h3C, "read_selfdriven");
    rd(5'h08, "read_model");
    @(negedge clk); tb_val = 8'h3C;
    wr(5'h04, 32'h00);
    @(negedge clk); tb_val = 8'h00;
    ticks(8);

    // 3. debounce: 3-cycle glitch dropped, 4-cycle level accepted at exactly 2+DEB
    @(negedge clk); tb_val[0] = 1'b1;
    repeat (3) @(negedge clk);
    tb_val[0] = 1'b0;
    for (int i = 0; i < 8; i++) rdk(5'h08, 0, "glitch_read");
    rdk(5'h1C, 0, "glitch_stat");
    @(negedge clk); tb_val[0] = 1'b1;
    repeat (5) @(posedge clk);
    rdk(5'h08, 0, "deb_lat5");
    rdk(5'h08, 1, "deb_lat6");
    @(negedge clk); tb_val = 8'h02;
    ticks(10);

    // 4. edge interrupts and W1C
    wr(5'h14, 32'h01); wr(5'h18, 32'h02);
    @(negedge clk); tb_val = 8'h03;
    ticks(8);
    rdk(5'h1C, 32'h01, "stat_rise0");
    chk("irq_rise0", 32'(o_irq), 1);
    @(negedge clk); tb_val = 8'h01;
    ticks(8);
    rdk(5'h1C, 32'h03, "stat_fall1");
    wr(5'h1C, 32'h01);
    rdk(5'h1C, 32'h02, "w1c_bit0");
    chk("irq_still", 32'(o_irq), 1);
    wr(5'h1C, 32'h02);
    rdk(5'h1C, 32'h00, "w1c_bit1");
    chk("irq_clear", 32'(o_irq), 0);

    // 5. event beats a same-cycle W1C
    @(negedge clk); tb_val = 8'h00;
    ticks(10);
    @(negedge clk); tb_val[0] = 1'b1;
    repeat (6) @(posedge clk);
    wr(5'h1C, 32'h01);
    rdk(5'h1C, 32'h01, "event_wins");
    rd(5'h1C, "event_wins_model");

    // 6. async reset mid-debounce with an interrupt pending
    @(negedge clk); tb_val = 8'h51;
    wr(5'h00, 32'hA5); wr(5'h04, 32'hF0);
    ticks(1);
    @(negedge clk); tb_val[2] = 1'b1;
    ticks(2);
    #2 resetn = 1'b0;
    #1;
    chk("rst_irq", 32'(o_irq), 0);
    chk("rst_pads_z", 32'(gpio_pins), 32'h55);
    @(negedge clk); resetn = 1'b1;
    for (int i = 0; i < 8; i++) rdk(AW'(i * 4), 0, $sformatf("post_rst_reg%0h", i * 4));
    ticks(10);
    rdk(5'h1C, 0, "held_high_no_stat");
    rdk(5'h08, 32'h55, "held_high_read");
    wr(5'h00, 32'hA5);
    rdk(5'h0C, 0, "read_set");
    rdk(5'h10, 0, "read_clr");
    rdk(5'h1F, 0, "read_unmapped");
    rdk(5'h00, 32'hA5, "data_after_rst");
    @(negedge clk); i_sel = 1'b0; i_addr = 5'h00; #1;
    chk("rdata_nosel", o_rdata, 0);

    // 7. randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      if ($urandom_range(0, 5) == 0) tb_val = tb_val ^ GW'(1 << $urandom_range(0, GW - 1));
      op = int'($urandom_range(0, 9));
      ra = (op == 8) ? 5'h1F : (op == 9) ? 5'h02 : AW'(op * 4);
      op = int'($urandom_range(0, 3));
      i_addr  = ra;
      i_wdata = $urandom;
      i_sel   = (op != 0);
      i_we    = (op == 3);
      #1;
      chk("rnd_rdata", o_rdata, (i_sel && !i_we) ? mread(ra) : 0);
      chk("rnd_irq", 32'(o_irq), 32'(|m_stat));
    end
    @(negedge clk); i_sel = 1'b0; i_we = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
